// File: rtl/bridge_status_tracker_pkg.sv
// Shared widths, trace record layout and sizing helper for the bridge status tracker.
package bridge_status_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int STATE_W_DEF = 3;
  localparam int ERR_W_DEF   = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int TS_W_DEF    = 16;
  localparam int WD_W_DEF    = 16;

  // Channel index width; a single channel still needs one bit in the record.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int CH_IDX_W_DEF = clog2_min1(NUM_CH_DEF);
  localparam int TRACE_W_DEF  = TS_W_DEF + CH_IDX_W_DEF + STATE_W_DEF + ERR_W_DEF;

  typedef struct packed {
    logic [TS_W_DEF-1:0]     ts;
    logic [CH_IDX_W_DEF-1:0] ch;
    logic [STATE_W_DEF-1:0]  state;
    logic [ERR_W_DEF-1:0]    error;
  } trace_rec_t;

endpackage

// File: rtl/bridge_status_tracker_if.sv
// Trace read port: the drainer (master) pops records from the tracker (slave).
interface bridge_status_tracker_if
  import bridge_status_pkg::*;
#(
  parameter int DATA_W  = TRACE_W_DEF,
  parameter int LEVEL_W = $clog2(DEPTH_DEF) + 1
);
  logic               rd_en;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_data;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (output rd_en, input rd_valid, input rd_data, input fifo_level);
  modport slave  (input rd_en, output rd_valid, output rd_data, output fifo_level);
endinterface

// File: rtl/bridge_status_tracker_fifo.sv
// Synchronous show-ahead FIFO; push into a full FIFO succeeds only alongside a pop.
module bst_event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  // Gated so the read data is all-zero whenever nothing is held.
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bridge_status_tracker.sv
// Multi-channel bridge status tracker: change detection into a timestamped trace FIFO,
// per-channel busy watchdogs, sticky error flags and a saturating drop counter.
module bridge_status_tracker
  import bridge_status_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int STATE_W = STATE_W_DEF,
  parameter int ERR_W   = ERR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TS_W    = TS_W_DEF,
  parameter int WD_W    = WD_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_busy,
  input  logic [NUM_CH*STATE_W-1:0] ch_state,
  input  logic [NUM_CH*ERR_W-1:0]   ch_error,
  input  logic [WD_W-1:0]           busy_limit,
  input  logic                      clr_sticky,
  bridge_status_tracker_if.slave    trc,
  output logic [NUM_CH-1:0]         err_sticky,
  output logic [NUM_CH-1:0]         timeout,
  output logic [7:0]                drop_cnt,
  output logic                      all_idle
);
  localparam int CH_IDX_W = clog2_min1(NUM_CH);
  localparam int REC_W    = TS_W + CH_IDX_W + STATE_W + ERR_W;
  localparam int LVL_W    = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]                  ts;
  logic [NUM_CH*STATE_W-1:0]        prev_state;
  logic [NUM_CH*ERR_W-1:0]          prev_err;
  logic [NUM_CH-1:0]                pending, pending_nxt, evt, wr_mask;
  logic [NUM_CH-1:0]                err_nxt, to_nxt;
  logic [NUM_CH-1:0][TS_W-1:0]      pend_ts;
  logic [NUM_CH-1:0][STATE_W-1:0]   pend_state;
  logic [NUM_CH-1:0][ERR_W-1:0]     pend_err;
  logic [NUM_CH-1:0][WD_W-1:0]      wd_cnt, wd_nxt;
  logic                             wr_hit, push, pop, full;
  logic [CH_IDX_W-1:0]              wr_idx;
  logic [REC_W-1:0]                 push_data, fifo_rdata;
  logic                             fifo_valid;
  logic [LVL_W-1:0]                 fifo_lvl;
  logic [8:0]                       n_drop, drop_sum;
  logic [7:0]                       drop_nxt;

  always_comb begin
    evt     = '0;
    wd_nxt  = '0;
    err_nxt = clr_sticky ? '0 : err_sticky;
    to_nxt  = clr_sticky ? '0 : timeout;
    for (int i = 0; i < NUM_CH; i++) begin
      evt[i] = (ch_state[i*STATE_W +: STATE_W] != prev_state[i*STATE_W +: STATE_W]) ||
               ((ch_error[i*ERR_W +: ERR_W] != prev_err[i*ERR_W +: ERR_W]) &&
                (ch_error[i*ERR_W +: ERR_W] != '0));
      if (!ch_busy[i])          wd_nxt[i] = '0;
      else if (&wd_cnt[i])      wd_nxt[i] = wd_cnt[i];
      else                      wd_nxt[i] = wd_cnt[i] + WD_W'(1);
      if ((busy_limit != '0) && (wd_nxt[i] == busy_limit)) to_nxt[i] = 1'b1;
      if (ch_error[i*ERR_W +: ERR_W] != '0)                err_nxt[i] = 1'b1;
    end
  end

  // Writer: lowest-index pending channel wins the single push slot.
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        wr_hit = 1'b1;
        wr_idx = CH_IDX_W'(i);
      end
    end
    pop     = trc.rd_en && fifo_valid;
    push    = wr_hit && (!full || pop);
    wr_mask = '0;
    if (push) wr_mask[wr_idx] = 1'b1;
    push_data = {pend_ts[wr_idx], wr_idx, pend_state[wr_idx], pend_err[wr_idx]};
  end

  // A fresh event on a channel whose record is still waiting overwrites it (a drop),
  // unless that record is the one leaving this cycle.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (evt[i] && pending[i] && !wr_mask[i]) n_drop = n_drop + 9'd1;
    end
    pending_nxt = (pending & ~wr_mask) | evt;
    drop_sum    = (clr_sticky ? 9'd0 : {1'b0, drop_cnt}) + n_drop;
    drop_nxt    = (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      prev_state <= '0;
      prev_err   <= '0;
      pending    <= '0;
      pend_ts    <= '0;
      pend_state <= '0;
      pend_err   <= '0;
      wd_cnt     <= '0;
      err_sticky <= '0;
      timeout    <= '0;
      drop_cnt   <= '0;
      all_idle   <= 1'b0;
    end else begin
      ts         <= ts + TS_W'(1);
      prev_state <= ch_state;
      prev_err   <= ch_error;
      pending    <= pending_nxt;
      wd_cnt     <= wd_nxt;
      err_sticky <= err_nxt;
      timeout    <= to_nxt;
      drop_cnt   <= drop_nxt;
      all_idle   <= ~|ch_busy && ~|err_nxt && ~|to_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (evt[i]) begin
          pend_ts[i]    <= ts;
          pend_state[i] <= ch_state[i*STATE_W +: STATE_W];
          pend_err[i]   <= ch_error[i*ERR_W +: ERR_W];
        end
      end
    end
  end

  bst_event_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .full  (full),
    .level (fifo_lvl)
  );

  assign trc.rd_valid   = fifo_valid;
  assign trc.rd_data    = fifo_rdata;
  assign trc.fifo_level = fifo_lvl;
endmodule
